sort_maxfind_axil: RTL and testbench

- Parametrised successor to the 4-register sortingIP AXI4-Lite slave.
- Holds NUM_DATA data words that software writes over AXI4-Lite.
- On a software start, an internal FSM scans the first COUNT words at one compare per cycle and produces the max value and its index.
- Supports unsigned and signed compare, a sticky done flag, and a level interrupt. It sits behind the PS AXI interconnect as a memory-mapped peripheral.

---
 rtl/sort_maxfind_axil.sv | 268 ++++++++++++++++++++++++++
 tb/tb_sort_maxfind_axil.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_maxfind_axil.sv
// AXI4-Lite slave holding NUM_DATA words; a start command scans the first
// COUNT words one compare per cycle and reports the maximum and its index.
module sort_maxfind_axil #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_DATA           = 16
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            irq
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int WW = AW - 2;
    localparam int IW = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;

    localparam logic [WW:0] A_CTRL = (WW+1)'(0);
    localparam logic [WW:0] A_STAT = (WW+1)'(1);
    localparam logic [WW:0] A_CNT  = (WW+1)'(2);
    localparam logic [WW:0] A_MAX  = (WW+1)'(3);
    localparam logic [WW:0] A_IDX  = (WW+1)'(4);
    localparam logic [WW:0] DBASE  = (WW+1)'(16);
    localparam logic [WW:0] DEND   = (WW+1)'(16 + NUM_DATA);
    localparam logic [5:0]  CNT_MAX = 6'(NUM_DATA);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_data [NUM_DATA];
    logic [5:0]  r_count;
    logic        r_sgn;
    logic        r_irq_en;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_max;
    logic [5:0]  r_idx;
    logic [31:0] r_cur_max;
    logic [5:0]  r_cur_idx;
    logic [5:0]  r_ptr;
    logic        r_sgn_lat;

    logic        r_awready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;

    logic [WW:0]   w_wword;
    logic [WW:0]   w_rword;
    logic          w_wr_en;
    logic          w_w_data;
    logic          w_r_data;
    logic [IW-1:0] w_widx;
    logic [IW-1:0] w_ridx;
    logic          w_busy;
    logic          w_busy_err;
    logic          w_ctrl_wr;
    logic          w_stat_wr;
    logic          w_cnt_wr;
    logic          w_start;
    logic          w_cnt_ok;
    logic          w_start_ok;
    logic          w_start_bad;
    logic [31:0]   w_elem;
    logic          w_gt;
    logic [31:0]   w_rd;
    logic          w_unused;

    function automatic logic [31:0] f_strb(
        input logic [31:0] o,
        input logic [31:0] d,
        input logic [3:0]  s
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
        end
        return r;
    endfunction

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign w_wword  = {1'b0, s00_axi_awaddr[AW-1:2]};
    assign w_rword  = {1'b0, s00_axi_araddr[AW-1:2]};
    assign w_wr_en  = r_awready;
    assign w_w_data = (w_wword >= DBASE) && (w_wword < DEND);
    assign w_r_data = (w_rword >= DBASE) && (w_rword < DEND);
    assign w_widx   = IW'(w_wword - DBASE);
    assign w_ridx   = IW'(w_rword - DBASE);

    assign w_busy     = (r_state != S_IDLE);
    assign w_ctrl_wr  = w_wr_en && (w_wword == A_CTRL);
    assign w_stat_wr  = w_wr_en && (w_wword == A_STAT) && s00_axi_wstrb[0];
    assign w_cnt_wr   = w_wr_en && (w_wword == A_CNT);
    assign w_busy_err = w_wr_en && w_busy && (w_w_data || (w_wword == A_CNT));

    assign w_start     = w_ctrl_wr && s00_axi_wstrb[0] && s00_axi_wdata[0];
    assign w_cnt_ok    = (r_count != 6'd0) && (r_count <= CNT_MAX);
    assign w_start_ok  = w_start && !w_busy && w_cnt_ok;
    assign w_start_bad = w_start && !w_busy && !w_cnt_ok;

    assign w_elem = r_data[r_ptr[IW-1:0]];
    assign w_gt   = r_sgn_lat ? ($signed(w_elem) > $signed(r_cur_max))
                              : (w_elem > r_cur_max);

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_start_ok) w_next = S_SCAN;
            S_SCAN: if (r_ptr >= r_count - 6'd1) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Scan datapath and sticky status; a DONE set beats a same-cycle W1C.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_cur_max <= '0;
            r_cur_idx <= '0;
            r_ptr     <= '0;
            r_sgn_lat <= 1'b0;
            r_max     <= '0;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_cur_max <= r_data[0];
                r_cur_idx <= '0;
                r_ptr     <= 6'd1;
                r_sgn_lat <= s00_axi_wdata[1];
            end
            if (r_state == S_SCAN && r_ptr < r_count) begin
                if (w_gt) begin
                    r_cur_max <= w_elem;
                    r_cur_idx <= r_ptr;
                end
                r_ptr <= r_ptr + 6'd1;
            end
            if (r_state == S_DONE) begin
                r_max <= r_cur_max;
                r_idx <= r_cur_idx;
            end
            if (w_stat_wr && s00_axi_wdata[1]) r_done <= 1'b0;
            if (w_stat_wr && s00_axi_wdata[2]) r_err <= 1'b0;
            if (w_start_ok) r_done <= 1'b0;
            if (w_start_bad) begin
                r_err  <= 1'b1;
                r_done <= 1'b1;
            end
            if (r_state == S_DONE) r_done <= 1'b1;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < NUM_DATA; i++) r_data[i] <= '0;
            r_count  <= CNT_MAX;
            r_sgn    <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_wr_en && w_w_data && !w_busy) begin
                r_data[w_widx] <= f_strb(r_data[w_widx], s00_axi_wdata,
                                         s00_axi_wstrb);
            end
            if (w_cnt_wr && !w_busy && s00_axi_wstrb[0]) begin
                r_count <= s00_axi_wdata[5:0];
            end
            if (w_ctrl_wr && s00_axi_wstrb[0]) begin
                r_sgn    <= s00_axi_wdata[1];
                r_irq_en <= s00_axi_wdata[2];
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            r_awready <= s00_axi_awvalid && s00_axi_wvalid &&
                         !r_bvalid && !r_awready;
            if (w_wr_en) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_busy_err ? 2'b10 : 2'b00;
            end else if (r_bvalid && s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        unique case (1'b1)
            w_r_data:           w_rd = r_data[w_ridx];
            (w_rword == A_CTRL): w_rd = {29'd0, r_irq_en, r_sgn, 1'b0};
            (w_rword == A_STAT): w_rd = {29'd0, r_err, r_done, w_busy};
            (w_rword == A_CNT):  w_rd = {26'd0, r_count};
            (w_rword == A_MAX):  w_rd = r_max;
            (w_rword == A_IDX):  w_rd = {26'd0, r_idx};
            default:            w_rd = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= s00_axi_arvalid && !r_rvalid && !r_arready;
            if (r_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd;
            end else if (r_rvalid && s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_awready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = 2'b00;
    assign irq             = r_done & r_irq_en;

endmodule

// File: tb/tb_sort_maxfind_axil.sv
// Bench for sort_maxfind_axil: register table, scan corner sequences,
// and randomized scans checked against a reference max/index model.
module tb_sort_maxfind_axil;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] md [16];

    sort_maxfind_axil #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(8),
        .NUM_DATA(16)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_areset(rst),
        .s00_axi_awaddr(awaddr),
        .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata),
        .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready),
        .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_wr(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp,
                          output int t_hs);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        resp = 2'b11;
        t_hs = cyc;
        n = 0;
        tick();
        while (!(awready && wready) && n < 20) begin
            tick();
            n++;
        end
        if (!(awready && wready)) begin
            chk("aw_timeout", 32'd0, 32'd1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        t_hs = cyc;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        if (!bvalid) chk("b_timeout", 32'd0, 32'd1);
        else resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
        int n;
        araddr = a;
        arvalid = 1'b1;
        d = 'x; resp = 2'b11;
        n = 0;
        tick();
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        if (!arready) begin
            chk("ar_timeout", 32'd0, 32'd1);
            arvalid = 1'b0;
            return;
        end
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        if (!rvalid) chk("r_timeout", 32'd0, 32'd1);
        else begin
            d = rdata;
            resp = rresp;
        end
        tick();
        rready = 1'b0;
    endtask

    task automatic wr_ok(input string nm, input logic [7:0] a,
                         input logic [31:0] d);
        logic [1:0] r;
        int t;
        axi_wr(a, d, 4'hF, r, t);
        chk(nm, {30'd0, r}, 32'd0);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0] r;
        axi_rd(a, d, r);
        chk(nm, d, exp);
    endtask

    task automatic wait_done();
        logic [31:0] d;
        logic [1:0] r;
        int n;
        n = 0;
        d = '0;
        do begin
            axi_rd(8'h04, d, r);
            n++;
        end while (!d[1] && n < 40);
        chk("done_status", d, 32'h2);
    endtask

    // Signed order maps to unsigned order by flipping the sign bit.
    function automatic void model(input int n, input bit sgn,
                                  output logic [31:0] mx,
                                  output logic [31:0] ix);
        logic [31:0] flip;
        logic [31:0] best;
        bit found;
        flip = sgn ? 32'h8000_0000 : 32'h0;
        best = md[0] ^ flip;
        for (int i = 1; i < n; i++) begin
            if ((md[i] ^ flip) > best) best = md[i] ^ flip;
        end
        mx = best ^ flip;
        ix = 0;
        found = 0;
        for (int i = 0; i < n; i++) begin
            if (!found && md[i] == mx) begin
                ix = 32'(i);
                found = 1;
            end
        end
    endfunction

    typedef struct {
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [7:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] emx;
        logic [31:0] eix;
        int t;
        int n;
        bit sgn;

        tbl[0]  = '{8'h40, 32'd1,         4'hF, 8'h40, 32'd1};
        tbl[1]  = '{8'h44, 32'd2,         4'hF, 8'h44, 32'd2};
        tbl[2]  = '{8'h48, 32'd3,         4'hF, 8'h48, 32'd3};
        tbl[3]  = '{8'h4C, 32'd4,         4'hF, 8'h4C, 32'd4};
        tbl[4]  = '{8'h50, 32'hAABBCCDD,  4'h5, 8'h50, 32'h00BB00DD};
        tbl[5]  = '{8'h08, 32'h3F,        4'h0, 8'h08, 32'h10};
        tbl[6]  = '{8'h08, 32'hFFFFFF05,  4'hF, 8'h08, 32'h5};
        tbl[7]  = '{8'h00, 32'h6,         4'hF, 8'h00, 32'h6};
        tbl[8]  = '{8'h00, 32'h0,         4'hF, 8'h00, 32'h0};
        tbl[9]  = '{8'hFC, 32'h1234,      4'hF, 8'hFC, 32'h0};
        tbl[10] = '{8'h0C, 32'hFFFF,      4'hF, 8'h0C, 32'h0};
        tbl[11] = '{8'h7C, 32'hDEADBEEF,  4'hF, 8'h7C, 32'hDEADBEEF};
        tbl[12] = '{8'h40, 32'h0,         4'h0, 8'h43, 32'd1};
        tbl[13] = '{8'h80, 32'h55,        4'hF, 8'h10, 32'h0};

        repeat (3) tick();
        chk("rst_ready_valid",
            {26'd0, awready, wready, bvalid, arready, rvalid, irq}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        rst = 1'b0;
        tick();
        rd_chk("rst_status", 8'h04, 32'h0);
        rd_chk("rst_count", 8'h08, 32'h10);

        for (int i = 0; i < 14; i++) begin
            axi_wr(tbl[i].wa, tbl[i].wd, tbl[i].ws, r, t);
            chk($sformatf("tbl%0d_bresp", i), {30'd0, r}, 32'd0);
            axi_rd(tbl[i].ra, d, r);
            chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp);
            chk($sformatf("tbl%0d_rresp", i), {30'd0, r}, 32'd0);
        end

        // Max in the middle, exact completion latency via irq.
        for (int i = 0; i < 16; i++) md[i] = 32'(i);
        md[9] = 32'h7FFF_FFFF;
        for (int i = 0; i < 16; i++) wr_ok("a_data", 8'(8'h40 + 4*i), md[i]);
        wr_ok("a_count", 8'h08, 32'd16);
        axi_wr(8'h00, 32'h5, 4'hF, r, t);
        chk("a_start_bresp", {30'd0, r}, 32'd0);
        while (cyc < t + 16) tick();
        chk("a_irq_early", {31'd0, irq}, 32'd0);
        tick();
        chk("a_irq_at_T17", {31'd0, irq}, 32'd1);
        rd_chk("a_status", 8'h04, 32'h2);
        rd_chk("a_max", 8'h0C, 32'h7FFF_FFFF);
        rd_chk("a_idx", 8'h10, 32'd9);
        wr_ok("a_w1c", 8'h04, 32'h2);
        chk("a_irq_clr", {31'd0, irq}, 32'd0);

        // Unsigned vs signed with a tie.
        wr_ok("b_d0", 8'h40, 32'hFFFF_FFFF);
        wr_ok("b_d1", 8'h44, 32'd5);
        wr_ok("b_d2", 8'h48, 32'd5);
        wr_ok("b_d3", 8'h4C, 32'd2);
        wr_ok("b_count", 8'h08, 32'd4);
        wr_ok("b_start_u", 8'h00, 32'h1);
        wait_done();
        rd_chk("b_max_u", 8'h0C, 32'hFFFF_FFFF);
        rd_chk("b_idx_u", 8'h10, 32'd0);
        wr_ok("b_start_s", 8'h00, 32'h3);
        wait_done();
        rd_chk("b_max_s", 8'h0C, 32'd5);
        rd_chk("b_idx_s", 8'h10, 32'd1);

        // Illegal counts flag an error instead of scanning.
        wr_ok("c_count0", 8'h08, 32'd0);
        wr_ok("c_start0", 8'h00, 32'h1);
        rd_chk("c_status0", 8'h04, 32'h6);
        rd_chk("c_max_kept", 8'h0C, 32'd5);
        wr_ok("c_clr0", 8'h04, 32'h6);
        rd_chk("c_status_clr", 8'h04, 32'h0);
        wr_ok("c_count17", 8'h08, 32'd17);
        wr_ok("c_start17", 8'h00, 32'h1);
        rd_chk("c_status17", 8'h04, 32'h6);
        wr_ok("c_clr17", 8'h04, 32'h6);

        // Writes while busy.
        for (int i = 0; i < 16; i++) md[i] = 32'(3 * i);
        md[2] = 32'd1;
        for (int i = 0; i < 16; i++) wr_ok("d_data", 8'(8'h40 + 4*i), md[i]);
        wr_ok("d_count", 8'h08, 32'd16);
        wr_ok("d_start", 8'h00, 32'h1);
        rd_chk("d_busy", 8'h04, 32'h1);
        axi_wr(8'h48, 32'hFFFF_FFFF, 4'hF, r, t);
        chk("d_data_slverr", {30'd0, r}, 32'h2);
        wr_ok("d_restart", 8'h00, 32'h1);
        axi_wr(8'h08, 32'd5, 4'hF, r, t);
        chk("d_count_slverr", {30'd0, r}, 32'h2);
        wait_done();
        model(16, 1'b0, emx, eix);
        rd_chk("d_max", 8'h0C, emx);
        rd_chk("d_idx", 8'h10, eix);
        rd_chk("d_data2_kept", 8'h48, 32'd1);
        rd_chk("d_count_kept", 8'h08, 32'd16);

        for (int it = 0; it < 10; it++) begin
            n = (it == 0) ? 1 : int'($urandom_range(1, 16));
            sgn = it[0];
            for (int i = 0; i < 16; i++) begin
                md[i] = (it % 3 == 0) ? $urandom_range(0, 3) : $urandom;
                if (it % 3 == 1 && i % 2 == 0) md[i] = md[i] | 32'h8000_0000;
                wr_ok("r_data", 8'(8'h40 + 4*i), md[i]);
            end
            wr_ok("r_count", 8'h08, 32'(n));
            wr_ok("r_start", 8'h00, {30'd0, sgn, 1'b1});
            wait_done();
            model(n, sgn, emx, eix);
            rd_chk($sformatf("r%0d_max", it), 8'h0C, emx);
            rd_chk($sformatf("r%0d_idx", it), 8'h10, eix);
        end

        // Reset in the middle of a scan.
        wr_ok("e_count", 8'h08, 32'd16);
        wr_ok("e_start", 8'h00, 32'h5);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("e_irq", {31'd0, irq}, 32'd0);
        rd_chk("e_status", 8'h04, 32'h0);
        rd_chk("e_count_rst", 8'h08, 32'h10);
        rd_chk("e_ctrl_rst", 8'h00, 32'h0);
        rd_chk("e_max_rst", 8'h0C, 32'h0);
        rd_chk("e_data_rst", 8'h40, 32'h0);
        repeat (20) tick();
        rd_chk("e_status_late", 8'h04, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
